// File: rtl/symm_row_sumsq_pkg.sv
// Shared fixed-point constants and FSM state type for the symmetric orthogonalisation datapath.
// The row-normalisation controller imports this package too.
package symm_pkg;
  localparam int DATA_W    = 26;
  localparam int FRAC_BITS = 20;
  localparam int ACC_W     = 2 * DATA_W + 2;

  typedef logic signed [DATA_W-1:0] data_t;

  localparam data_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
endpackage

// File: rtl/symm_row_sumsq_if.sv
// Request/matrix/result bundle between a requester (master) and the row sum-of-squares engine (slave).
interface symm_row_sumsq_if;
  import symm_pkg::*;

  logic  start_nsum;
  data_t i11, i12, i13, i14;
  data_t i21, i22, i23, i24;
  data_t i31, i32, i33, i34;
  data_t i41, i42, i43, i44;
  logic  busy_nsum;
  logic  done_nsum;
  logic  sat_nsum;
  data_t sum1, sum2, sum3, sum4;

  modport master (
    output start_nsum,
    output i11, i12, i13, i14, i21, i22, i23, i24,
    output i31, i32, i33, i34, i41, i42, i43, i44,
    input  busy_nsum, done_nsum, sat_nsum, sum1, sum2, sum3, sum4
  );

  modport slave (
    input  start_nsum,
    input  i11, i12, i13, i14, i21, i22, i23, i24,
    input  i31, i32, i33, i34, i41, i42, i43, i44,
    output busy_nsum, done_nsum, sat_nsum, sum1, sum2, sum3, sum4
  );
endinterface

// File: rtl/symm_row_sumsq_sq_acc.sv
// Single-multiplier square / rescale / accumulate unit with saturated row result.
// acc_sat and sat_flag reflect the accumulator including the current element x.
module symm_sq_acc
  import symm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  en,
  input  data_t x,
  output data_t acc_sat,
  output logic  sat_flag
);

  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    scaled;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    sat_lim;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;

  always_comb begin
    x_ext    = $signed({{DATA_W{x[DATA_W-1]}}, x});
    prod     = x_ext * x_ext;
    scaled   = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod}) >>> FRAC_BITS;
    sum      = acc_q + scaled;
    sat_lim  = $signed({{(ACC_W-DATA_W){1'b0}}, SAT_MAX});
    sat_flag = (sum > sat_lim);
    acc_sat  = sat_flag ? SAT_MAX : sum[DATA_W-1:0];
    // clr wins over en so the row-closing element is written out and dropped in one cycle
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/symm_row_sumsq.sv
// Per-row sum of squares of a captured 4x4 matrix, one element per cycle, rows written as they finish.
// Holds the FSM, element index, input capture register and registered outputs.
module symm_row_sumsq
  import symm_pkg::*;
(
  input logic             clk_nsum,
  input logic             rst_nsum,
  symm_row_sumsq_if.slave bus
);

  data_t  in_arr [16];
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  data_t  cap_q [16];
  data_t  cap_d [16];
  data_t  sum_q [4];
  data_t  sum_d [4];
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   sat_q, sat_d;
  logic   acc_clr, acc_en;
  data_t  acc_sat;
  logic   sat_flag;

  always_comb begin
    in_arr[0]  = bus.i11;  in_arr[1]  = bus.i12;  in_arr[2]  = bus.i13;  in_arr[3]  = bus.i14;
    in_arr[4]  = bus.i21;  in_arr[5]  = bus.i22;  in_arr[6]  = bus.i23;  in_arr[7]  = bus.i24;
    in_arr[8]  = bus.i31;  in_arr[9]  = bus.i32;  in_arr[10] = bus.i33;  in_arr[11] = bus.i34;
    in_arr[12] = bus.i41;  in_arr[13] = bus.i42;  in_arr[14] = bus.i43;  in_arr[15] = bus.i44;
  end

  symm_sq_acc u_sq_acc (
    .clk      (clk_nsum),
    .rst      (rst_nsum),
    .clr      (acc_clr),
    .en       (acc_en),
    .x        (cap_q[idx_q]),
    .acc_sat  (acc_sat),
    .sat_flag (sat_flag)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_nsum) begin
          cap_d   = in_arr;
          idx_d   = '0;
          sat_d   = 1'b0;
          busy_d  = 1'b1;
          acc_clr = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        idx_d  = idx_q + 4'd1;
        if (idx_q[1:0] == 2'd3) begin
          sum_d[idx_q[3:2]] = acc_sat;
          acc_clr           = 1'b1;
          if (sat_flag) sat_d = 1'b1;
        end
        if (idx_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        // busy drops and done rises together so a start in the done cycle is accepted
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_nsum) begin
    if (rst_nsum) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int k = 0; k < 16; k++) cap_q[k] <= '0;
      for (int k = 0; k < 4; k++)  sum_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      cap_q   <= cap_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.busy_nsum = busy_q;
  assign bus.done_nsum = done_q;
  assign bus.sat_nsum  = sat_q;
  assign bus.sum1      = sum_q[0];
  assign bus.sum2      = sum_q[1];
  assign bus.sum3      = sum_q[2];
  assign bus.sum4      = sum_q[3];

endmodule

// File: tb/tb_symm_row_sumsq.sv
// Scoreboard bench for symm_row_sumsq: expected row sums queued at start, checked at done and per-row edges.
module tb_symm_row_sumsq;
  import symm_pkg::*;

  typedef struct packed {
    logic [3:0][DATA_W-1:0] s;
    logic                   sat;
  } exp_t;

  logic clk;
  logic rst;
  symm_row_sumsq_if bus ();

  symm_row_sumsq dut (
    .clk_nsum (clk),
    .rst_nsum (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  exp_t  sb [$];
  data_t mat [16];
  data_t drv [16];
  data_t cur [4];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got no finish, need finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    bus.i11 = drv[0];  bus.i12 = drv[1];  bus.i13 = drv[2];  bus.i14 = drv[3];
    bus.i21 = drv[4];  bus.i22 = drv[5];  bus.i23 = drv[6];  bus.i24 = drv[7];
    bus.i31 = drv[8];  bus.i32 = drv[9];  bus.i33 = drv[10]; bus.i34 = drv[11];
    bus.i41 = drv[12]; bus.i42 = drv[13]; bus.i43 = drv[14]; bus.i44 = drv[15];
  endtask

  task automatic junk_inputs();
    for (int k = 0; k < 16; k++) drv[k] = data_t'($urandom);
    drive_inputs();
  endtask

  function automatic data_t get_sum(input int r);
    case (r)
      0:       return bus.sum1;
      1:       return bus.sum2;
      2:       return bus.sum3;
      default: return bus.sum4;
    endcase
  endfunction

  // Reference: floor(x*x / 2^20) summed per row, clamped at 2^25-1
  function automatic exp_t model();
    exp_t e;
    e.sat = 1'b0;
    for (int r = 0; r < 4; r++) begin
      longint acc = 0;
      for (int c = 0; c < 4; c++) begin
        longint x = longint'(mat[4*r+c]);
        acc += (x * x) >>> FRAC_BITS;
      end
      if (acc > 64'sd33554431) begin
        e.s[r] = DATA_W'(33554431);
        e.sat  = 1'b1;
      end else begin
        e.s[r] = acc[DATA_W-1:0];
      end
    end
    return e;
  endfunction

  task automatic start_run();
    drv = mat;
    drive_inputs();
    bus.start_nsum = 1'b1;
    sb.push_back(model());
    tick();
    bus.start_nsum = 1'b0;
    junk_inputs();
  endtask

  // Walks edges 1..17 after a start; returns in the done cycle
  task automatic run_body(input string name, input bit glitch);
    exp_t nw;
    exp_t got;
    nw = sb[$];
    for (int e = 1; e <= 17; e++) begin
      if (glitch && (e == 5 || e == 16)) begin
        junk_inputs();
        bus.start_nsum = 1'b1;
      end
      tick();
      bus.start_nsum = 1'b0;
      if (e % 4 == 3) begin
        checks++;
        if (get_sum(e / 4) !== cur[e / 4]) begin
          errors++;
          $display("FAIL %s row%0d_hold edge=%0d got=%0d want=%0d", name, e / 4 + 1, e, get_sum(e / 4), cur[e / 4]);
        end
      end
      if (e % 4 == 0 && e <= 16) begin
        checks++;
        if (get_sum(e / 4 - 1) !== data_t'(nw.s[e / 4 - 1])) begin
          errors++;
          $display("FAIL %s row%0d_write edge=%0d got=%0d want=%0d", name, e / 4, e, get_sum(e / 4 - 1), nw.s[e / 4 - 1]);
        end
        cur[e / 4 - 1] = data_t'(nw.s[e / 4 - 1]);
      end
      checks++;
      if (e < 17) begin
        if (bus.done_nsum !== 1'b0 || bus.busy_nsum !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_phase edge=%0d got done=%b busy=%b want done=0 busy=1", name, e, bus.done_nsum, bus.busy_nsum);
        end
      end else begin
        if (bus.done_nsum !== 1'b1 || bus.busy_nsum !== 1'b0) begin
          errors++;
          $display("FAIL %s done_edge17 got done=%b busy=%b want done=1 busy=0", name, bus.done_nsum, bus.busy_nsum);
        end
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard got empty queue want one entry", name);
    end else begin
      got.s[0] = bus.sum1;
      got.s[1] = bus.sum2;
      got.s[2] = bus.sum3;
      got.s[3] = bus.sum4;
      got.sat  = bus.sat_nsum;
      nw = sb.pop_front();
      if (got !== nw) begin
        errors++;
        $display("FAIL %s result got=%0d,%0d,%0d,%0d sat=%b want=%0d,%0d,%0d,%0d sat=%b", name,
                 got.s[0], got.s[1], got.s[2], got.s[3], got.sat, nw.s[0], nw.s[1], nw.s[2], nw.s[3], nw.sat);
      end
    end
    $display("txn %s sums=%0d,%0d,%0d,%0d sat=%b", name, bus.sum1, bus.sum2, bus.sum3, bus.sum4, bus.sat_nsum);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.sum1 !== '0 || bus.sum2 !== '0 || bus.sum3 !== '0 || bus.sum4 !== '0) begin
      errors++;
      $display("FAIL %s sums got=%0d,%0d,%0d,%0d want=0,0,0,0", name, bus.sum1, bus.sum2, bus.sum3, bus.sum4);
    end
    checks++;
    if (bus.busy_nsum !== 1'b0 || bus.done_nsum !== 1'b0 || bus.sat_nsum !== 1'b0) begin
      errors++;
      $display("FAIL %s flags got busy=%b done=%b sat=%b want 0,0,0", name, bus.busy_nsum, bus.done_nsum, bus.sat_nsum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_nsum = 1'b0;
    junk_inputs();
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    for (int r = 0; r < 4; r++) cur[r] = '0;
    tick();
    check_idle_outputs("reset_idle");
    $display("txn reset");
  endtask

  task automatic test_identity();
    for (int k = 0; k < 16; k++) mat[k] = (k % 5 == 0) ? data_t'(1048576) : '0;
    start_run();
    run_body("identity", 1'b0);
    checks++;
    if (bus.sum3 !== data_t'(1048576) || bus.sat_nsum !== 1'b0) begin
      errors++;
      $display("FAIL identity const got sum3=%0d sat=%b want 1048576 sat=0", bus.sum3, bus.sat_nsum);
    end
    tick();
  endtask

  task automatic test_half_and_neg();
    for (int k = 0; k < 16; k++) mat[k] = data_t'(524288);
    start_run();
    run_body("half", 1'b0);
    tick();
    for (int k = 0; k < 16; k++) mat[k] = data_t'(-1048576);
    start_run();
    run_body("neg_one", 1'b0);
    checks++;
    if (bus.sum4 !== data_t'(4194304)) begin
      errors++;
      $display("FAIL neg_one const got sum4=%0d want 4194304", bus.sum4);
    end
    tick();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 16; k++) mat[k] = (k < 4) ? data_t'(4194304) : '0;
    start_run();
    run_body("saturate", 1'b0);
    checks++;
    if (bus.sum1 !== data_t'(33554431) || bus.sat_nsum !== 1'b1 || bus.sum2 !== '0) begin
      errors++;
      $display("FAIL saturate const got sum1=%0d sat=%b sum2=%0d want 33554431 sat=1 sum2=0", bus.sum1, bus.sat_nsum, bus.sum2);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    for (int k = 0; k < 16; k++) mat[k] = data_t'(int'($urandom_range(0, 4194304)) - 2097152);
    start_run();
    run_body("start_busy", 1'b1);
    tick();
    checks++;
    if (bus.done_nsum !== 1'b0 || bus.busy_nsum !== 1'b0) begin
      errors++;
      $display("FAIL start_busy single_done got done=%b busy=%b want done=0 busy=0", bus.done_nsum, bus.busy_nsum);
    end
  endtask

  task automatic test_mid_reset();
    int pulses;
    for (int k = 0; k < 16; k++) mat[k] = data_t'(int'($urandom_range(0, 2097152)) - 1048576);
    start_run();
    for (int e = 1; e <= 8; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("mid_reset");
    sb.delete();
    for (int r = 0; r < 4; r++) cur[r] = '0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.done_nsum === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_reset no_done got pulses=%0d want 0", pulses);
    end
    $display("txn mid_reset");
    for (int k = 0; k < 16; k++) mat[k] = data_t'(int'($urandom_range(0, 4194304)) - 2097152);
    start_run();
    run_body("after_reset", 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) mat[k] = data_t'(int'($urandom_range(0, 2097152)) - 1048576);
    start_run();
    run_body("b2b_first", 1'b0);
    for (int k = 0; k < 16; k++) mat[k] = data_t'(int'($urandom_range(0, 4194304)) - 2097152);
    start_run();
    run_body("b2b_second", 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.start_nsum = 1'b0;
    test_reset();
    test_identity();
    test_half_and_neg();
    test_saturate();
    test_start_while_busy();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
